// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_ctrl
//  Description : Sequencer for the iterative multiplier/divider of the EXE
//                stage. Latches MULT/DIV operands once, holds the level-type
//                begin signal to the selected unit, waits for its end strobe
//                under a watchdog, short-circuits divide-by-zero, honours
//                pipeline cancel and presents a one-cycle HI/LO result strobe.
//  Ports       : clk, reset (async, active-high)
//                exe_valid, op_mult, op_div, op_sign, op_a, op_b, cancel
//                  - decode fields and flush from the ID->EXE path
//                mult_begin, div_begin, md_sign, md_op1, md_op2
//                  - start and operands toward the multiply/divide units
//                mult_end, product, div_end, quotient, remainder
//                  - completion and results from the units
//                busy, done, res_hi, res_lo, err
//                  - stall, result strobe and HI/LO values toward EXE->MEM
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_ctrl #(
    parameter int WDOG_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exe_valid,
    input  logic        op_mult,
    input  logic        op_div,
    input  logic        op_sign,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        cancel,
    output logic        mult_begin,
    output logic        div_begin,
    output logic        md_sign,
    output logic [31:0] md_op1,
    output logic [31:0] md_op2,
    input  logic        mult_end,
    input  logic [63:0] product,
    input  logic        div_end,
    input  logic [31:0] quotient,
    input  logic [31:0] remainder,
    output logic        busy,
    output logic        done,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [6:0]  c_wdog_last = 7'(WDOG_CYCLES - 1);
    localparam logic [31:0] c_all_ones  = 32'hFFFF_FFFF;

    state_t      r_state;
    state_t      w_next_state;
    logic [6:0]  r_wdog;
    logic        r_sign;
    logic [31:0] r_op1;
    logic [31:0] r_op2;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_err;

    logic        w_accept;
    logic        w_wdog_hit;
    logic        w_div_by_zero;

    // Reset gates accept so busy is low while reset is held, independent of
    // whatever the decode fields happen to show.
    assign w_accept      = ~reset & exe_valid & (op_mult | op_div) & ~cancel
                         & (r_state == ST_IDLE);
    assign w_wdog_hit    = (r_wdog == c_wdog_last);
    assign w_div_by_zero = ~op_mult & (op_b == 32'd0);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (op_mult) begin
                        w_next_state = ST_MUL;
                    end else if (w_div_by_zero) begin
                        w_next_state = ST_DONE;
                    end else begin
                        w_next_state = ST_DIV;
                    end
                end
            end
            ST_MUL: begin
                if (cancel) begin
                    w_next_state = ST_IDLE;
                end else if (mult_end || w_wdog_hit) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DIV: begin
                if (cancel) begin
                    w_next_state = ST_IDLE;
                end else if (div_end || w_wdog_hit) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand latch, watchdog and result capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wdog <= 7'd0;
            r_sign <= 1'b0;
            r_op1  <= 32'd0;
            r_op2  <= 32'd0;
            r_hi   <= 32'd0;
            r_lo   <= 32'd0;
            r_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_sign <= op_sign;
                        r_op1  <= op_a;
                        r_op2  <= op_b;
                        r_wdog <= 7'd0;
                        r_err  <= 1'b0;
                        // Divide-by-zero never reaches the divider; the
                        // MIPS-style result is formed right here.
                        if (w_div_by_zero) begin
                            r_hi <= op_a;
                            r_lo <= c_all_ones;
                        end
                    end
                end
                ST_MUL: begin
                    if (!cancel) begin
                        r_wdog <= r_wdog + 7'd1;
                        // A real completion in the expiry cycle beats the
                        // watchdog.
                        if (mult_end) begin
                            r_hi  <= product[63:32];
                            r_lo  <= product[31:0];
                            r_err <= 1'b0;
                        end else if (w_wdog_hit) begin
                            r_hi  <= 32'd0;
                            r_lo  <= 32'd0;
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_DIV: begin
                    if (!cancel) begin
                        r_wdog <= r_wdog + 7'd1;
                        if (div_end) begin
                            r_hi  <= remainder;
                            r_lo  <= quotient;
                            r_err <= 1'b0;
                        end else if (w_wdog_hit) begin
                            r_hi  <= 32'd0;
                            r_lo  <= 32'd0;
                            r_err <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs: begin strobes decode the state register only, so they drop
    // with reset asynchronously and never see a combinational input path.
    // ------------------------------------------------------------------
    assign mult_begin = (r_state == ST_MUL);
    assign div_begin  = (r_state == ST_DIV);
    assign md_sign    = r_sign;
    assign md_op1     = r_op1;
    assign md_op2     = r_op2;
    assign busy       = (r_state == ST_MUL) | (r_state == ST_DIV) | w_accept;
    // A flush arriving in the DONE cycle suppresses the result strobe.
    assign done       = (r_state == ST_DONE) & ~cancel;
    assign res_hi     = r_hi;
    assign res_lo     = r_lo;
    assign err        = r_err & done;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_ctrl
//  Description : Directed self-checking bench for muldiv_ctrl. The bench
//                plays the multiplier/divider by driving *_end and results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        exe_valid, op_mult, op_div, op_sign, cancel;
    logic [31:0] op_a, op_b;
    logic        mult_begin, div_begin, md_sign;
    logic [31:0] md_op1, md_op2;
    logic        mult_end, div_end;
    logic [63:0] product;
    logic [31:0] quotient, remainder;
    logic        busy, done, err;
    logic [31:0] res_hi, res_lo;

    int n_vec = 0;
    int n_err = 0;
    int busy_cnt;
    int cnt;

    always #5 clk = ~clk;

    muldiv_ctrl #(.WDOG_CYCLES(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .exe_valid  (exe_valid),
        .op_mult    (op_mult),
        .op_div     (op_div),
        .op_sign    (op_sign),
        .op_a       (op_a),
        .op_b       (op_b),
        .cancel     (cancel),
        .mult_begin (mult_begin),
        .div_begin  (div_begin),
        .md_sign    (md_sign),
        .md_op1     (md_op1),
        .md_op2     (md_op2),
        .mult_end   (mult_end),
        .product    (product),
        .div_end    (div_end),
        .quotient   (quotient),
        .remainder  (remainder),
        .busy       (busy),
        .done       (done),
        .res_hi     (res_hi),
        .res_lo     (res_lo),
        .err        (err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Step to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic m, input logic s, input logic [31:0] a, input logic [31:0] b);
        exe_valid = 1'b1;
        op_mult   = m;
        op_div    = ~m;
        op_sign   = s;
        op_a      = a;
        op_b      = b;
    endtask

    task automatic clear_op();
        exe_valid = 1'b0;
        op_mult   = 1'b0;
        op_div    = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        exe_valid = 0; op_mult = 0; op_div = 0; op_sign = 0; cancel = 0;
        op_a = 0; op_b = 0; mult_end = 0; div_end = 0;
        product = 0; quotient = 0; remainder = 0;

        // ---------------- reset state ----------------
        tick(); tick();
        chk("rst_outputs", {58'd0, mult_begin, div_begin, busy, done, err, md_sign}, 64'd0);
        chk("rst_ops", {md_op1, md_op2}, 64'd0);
        chk("rst_res", {res_hi, res_lo}, 64'd0);
        reset = 1'b0;

        // ---------------- cancel in IDLE blocks accept ----------------
        tick();
        issue(1'b1, 1'b1, 32'd1, 32'd1);
        cancel = 1'b1;
        #1;
        chk("idle_cancel_busy", {63'd0, busy}, 64'd0);
        tick();
        clear_op(); cancel = 1'b0;
        #1;
        chk("idle_cancel_begin", {63'd0, mult_begin}, 64'd0);

        // ---------------- MULT 7 * -3 signed, end on 33rd cycle ----------------
        tick();
        issue(1'b1, 1'b1, 32'd7, 32'hFFFF_FFFD);
        #1;
        chk("mul_accept_busy", {62'd0, busy, mult_begin}, 64'd2);
        busy_cnt = 1;
        for (int k = 1; k <= 33; k++) begin
            tick();
            if (k == 1) clear_op();   // exe_valid drop has no effect
            if (k == 33) begin
                mult_end = 1'b1;
                product  = 64'hFFFF_FFFF_FFFF_FFEB;
            end
            #1;
            if (k == 1) begin
                chk("mul_begin", {63'd0, mult_begin}, 64'd1);
                chk("mul_ops", {md_op1, md_op2}, {32'd7, 32'hFFFF_FFFD});
                chk("mul_sign", {63'd0, md_sign}, 64'd1);
            end
            if (busy) busy_cnt++;
        end
        tick();
        mult_end = 1'b0;
        #1;
        chk("mul_done", {61'd0, done, err, busy}, 64'd4);
        chk("mul_res", {res_hi, res_lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        chk("mul_busy_cycles", 64'(busy_cnt), 64'd34);
        tick(); #1;
        chk("mul_done_one_cycle", {62'd0, done, mult_begin}, 64'd0);

        // ---------------- DIVU 100 / 7, end on 33rd cycle ----------------
        issue(1'b0, 1'b0, 32'd100, 32'd7);
        for (int k = 1; k <= 33; k++) begin
            tick();
            if (k == 1) clear_op();
            if (k == 33) begin
                div_end   = 1'b1;
                quotient  = 32'd14;
                remainder = 32'd2;
            end
            #1;
            if (k == 1) chk("divu_begin_sign", {61'd0, div_begin, mult_begin, md_sign}, 64'd4);
        end
        tick();
        div_end = 1'b0;
        #1;
        chk("divu_done", {62'd0, done, err}, 64'd2);
        chk("divu_res", {res_hi, res_lo}, {32'd2, 32'd14});

        // ---------------- DIV 5 / 0 ----------------
        tick();
        issue(1'b0, 1'b1, 32'd5, 32'd0);
        #1;
        chk("div0_accept_busy", {63'd0, busy}, 64'd1);
        tick();
        clear_op();
        #1;
        chk("div0_done", {60'd0, done, err, div_begin, busy}, 64'd8);
        chk("div0_res", {res_hi, res_lo}, {32'd5, 32'hFFFF_FFFF});

        // ---------------- MULT cancelled in cycle 10 ----------------
        tick();
        issue(1'b1, 1'b0, 32'd11, 32'd13);
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 1) clear_op();
        end
        cancel = 1'b1;
        #1;
        chk("cancel_no_done", {63'd0, done}, 64'd0);
        tick();
        cancel = 1'b0;
        #1;
        chk("cancel_begin_drop", {61'd0, mult_begin, busy, done}, 64'd0);
        mult_end = 1'b1;
        product  = 64'd143;
        tick();
        mult_end = 1'b0;
        #1;
        chk("late_end_ignored", {62'd0, done, busy}, 64'd0);
        // next DIV after cancel: 9 / 4 signed -> q=2 r=1, end on 5th cycle
        issue(1'b0, 1'b1, 32'd9, 32'd4);
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 1) clear_op();
            if (k == 5) begin
                div_end = 1'b1; quotient = 32'd2; remainder = 32'd1;
            end
        end
        tick();
        div_end = 1'b0;
        #1;
        chk("post_cancel_div", {30'd0, done, err, res_hi}, {32'd2, 32'd1});
        chk("post_cancel_lo", {32'd0, res_lo}, 64'd2);

        // ---------------- watchdog: divider never ends ----------------
        tick();
        issue(1'b0, 1'b0, 32'd1, 32'd1);
        tick();
        clear_op();
        #1;
        cnt = 0;
        while (div_begin && cnt < 100) begin
            cnt++;
            tick();
            #1;
        end
        chk("wdog_begin_cycles", 64'(cnt), 64'd64);
        chk("wdog_done_err", {62'd0, done, err}, 64'd3);
        chk("wdog_res", {res_hi, res_lo}, 64'd0);

        // ---------------- div_end on the expiry cycle wins ----------------
        tick();
        issue(1'b0, 1'b0, 32'd50, 32'd5);
        for (int k = 1; k <= 64; k++) begin
            tick();
            if (k == 1) clear_op();
            if (k == 64) begin
                div_end = 1'b1; quotient = 32'd10; remainder = 32'd0;
            end
        end
        tick();
        div_end = 1'b0;
        #1;
        chk("wdog_edge_end_wins", {62'd0, done, err}, 64'd2);
        chk("wdog_edge_res", {res_hi, res_lo}, {32'd0, 32'd10});

        // ---------------- reset in the middle of DIV ----------------
        tick();
        issue(1'b0, 1'b0, 32'd8, 32'd2);
        tick();
        clear_op();
        tick(); tick();
        #1;
        chk("pre_reset_div_begin", {63'd0, div_begin}, 64'd1);
        reset = 1'b1;
        #1;
        chk("async_reset_outs", {60'd0, div_begin, busy, done, md_sign}, 64'd0);
        chk("async_reset_ops", {md_op1, md_op2}, 64'd0);
        reset = 1'b0;

        // ---------------- back-to-back MULTs after reset ----------------
        tick();
        issue(1'b1, 1'b0, 32'd3, 32'd4);
        tick();
        clear_op();
        mult_end = 1'b1; product = 64'd12;
        tick();
        mult_end = 1'b0;
        #1;
        chk("b2b_mul1", {31'd0, done, res_lo}, {32'd1, 32'd12});
        tick();
        issue(1'b1, 1'b0, 32'd5, 32'd6);
        #1;
        chk("b2b_mul2_accept", {62'd0, busy, mult_begin}, 64'd2);
        tick();
        clear_op();
        mult_end = 1'b1; product = 64'd30;
        #1;
        chk("b2b_mul2_begin", {63'd0, mult_begin}, 64'd1);
        tick();
        mult_end = 1'b0;
        #1;
        chk("b2b_mul2_done", {62'd0, done, err}, 64'd2);
        chk("b2b_mul2_res", {res_hi, res_lo}, 64'd30);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
